// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch front end that feeds the decode stage. It produces word
// addresses, issues them to instruction memory over a req/ack handshake with
// variable response latency, buffers the returned words in an in-order
// prefetch queue and presents one instruction per cycle to decode. A redirect
// flushes the queue and marks every in-flight response as stale so that it is
// thrown away when it eventually returns.
//
// Ports:
//   i_clk          clock, all state updates on the rising edge
//   i_rst          synchronous reset, active-high
//   i_redirect     flush and restart fetching at i_redirect_pc
//   i_redirect_pc  new fetch word address
//   i_stall        decode cannot take an instruction this cycle
//   o_inst         queue head instruction word, 0 when invalid
//   o_inst_valid   o_inst / o_inst_pc hold a valid queue head
//   o_inst_pc      word address of o_inst, 0 when invalid
//   o_imem_req     memory request valid
//   o_imem_addr    requested word address
//   i_imem_ack     memory accepts the request this cycle
//   i_imem_rvalid  response valid, responses return in request order
//   i_imem_rdata   response instruction word
// ---------------------------------------------------------------------------
module inst_fetch #(
   parameter int          DEPTH    = 4,
   parameter int          MAX_OUT  = 2,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic        i_stall,
   output logic [31:0] o_inst,
   output logic        o_inst_valid,
   output logic [31:0] o_inst_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata
);

   localparam int QW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int OW = $clog2(MAX_OUT + 1);
   localparam int TW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(MAX_OUT - 1);

   // Prefetch queue: circular buffer of {pc, inst}
   logic [31:0]   q_pc   [DEPTH];
   logic [31:0]   q_inst [DEPTH];
   logic [QW-1:0] q_rd;
   logic [QW-1:0] q_wr;
   logic [CW-1:0] count;

   // Tag FIFO remembering the pc of every live outstanding request
   logic [31:0]   t_pc [MAX_OUT];
   logic [TW-1:0] t_rd;
   logic [TW-1:0] t_wr;

   logic [31:0]   fetch_pc;
   logic [OW-1:0] outstanding;
   logic [OW-1:0] drop;

   logic issue_ok;
   logic fire;
   logic resp_drop;
   logic resp_keep;
   logic push;
   logic pop;

   // The tag FIFO depth need not be a power of two, so wrap explicitly
   function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
      return (p == T_LAST) ? '0 : p + TW'(1);
   endfunction

   // Issue only when every response that could come back is guaranteed a
   // queue slot, and when live plus stale requests leave room in the
   // outstanding budget. Stale requests still occupy the memory pipeline.
   always_comb begin
      issue_ok = ((32'(count) + 32'(outstanding)) < 32'(DEPTH)) &&
                 ((32'(outstanding) + 32'(drop)) < 32'(MAX_OUT));
      fire     = o_imem_req & i_imem_ack;
      // Stale responses are consumed first since they were issued earlier
      resp_drop = i_imem_rvalid && (drop != '0);
      resp_keep = i_imem_rvalid && (drop == '0) && (outstanding != '0);
      push      = resp_keep && !i_redirect && !i_rst;
      pop       = o_inst_valid && !i_stall && !i_redirect;
   end

   assign o_imem_req   = issue_ok && !i_redirect && !i_rst;
   assign o_imem_addr  = fetch_pc;
   assign o_inst_valid = (count != '0);
   assign o_inst       = o_inst_valid ? q_inst[q_rd] : 32'd0;
   assign o_inst_pc    = o_inst_valid ? q_pc[q_rd]   : 32'd0;

   // Control state. A redirect hands every live request over to the drop
   // counter; a response arriving in the same cycle is settled against the
   // old counters before that hand-over.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         fetch_pc    <= RESET_PC;
         count       <= '0;
         q_rd        <= '0;
         q_wr        <= '0;
         t_rd        <= '0;
         t_wr        <= '0;
         outstanding <= '0;
         drop        <= '0;
      end else if (i_redirect) begin
         fetch_pc    <= i_redirect_pc;
         count       <= '0;
         q_rd        <= '0;
         q_wr        <= '0;
         t_rd        <= '0;
         t_wr        <= '0;
         outstanding <= '0;
         drop        <= (drop - OW'(resp_drop)) + (outstanding - OW'(resp_keep));
      end else begin
         if (fire) begin
            fetch_pc <= fetch_pc + 32'd1;
            t_wr     <= tag_next(t_wr);
         end
         if (resp_keep) begin
            t_rd <= tag_next(t_rd);
         end
         if (push) begin
            q_wr <= q_wr + QW'(1);
         end
         if (pop) begin
            q_rd <= q_rd + QW'(1);
         end
         count       <= count + CW'(push) - CW'(pop);
         outstanding <= outstanding + OW'(fire) - OW'(resp_keep);
         drop        <= drop - OW'(resp_drop);
      end
   end

   // Storage arrays carry no reset; occupancy is tracked by the pointers
   always_ff @(posedge i_clk) begin
      if (fire) begin
         t_pc[t_wr] <= fetch_pc;
      end
      if (push) begin
         q_pc[q_wr]   <= t_pc[t_rd];
         q_inst[q_wr] <= i_imem_rdata;
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A queue-based reference model of the
// fetch unit and a behavioural in-order memory with configurable latency run
// alongside the DUT; each scenario task drives stimulus and compares the DUT
// outputs with the model every cycle.
// ---------------------------------------------------------------------------
module tb_inst_fetch;

   localparam int          DEPTH    = 4;
   localparam int          MAX_OUT  = 2;
   localparam logic [31:0] RESET_PC = 32'd0;

   logic        i_clk;
   logic        i_rst;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        i_stall;
   logic [31:0] o_inst;
   logic        o_inst_valid;
   logic [31:0] o_inst_pc;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_ack;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;

   inst_fetch #(
      .DEPTH    (DEPTH),
      .MAX_OUT  (MAX_OUT),
      .RESET_PC (RESET_PC)
   ) dut (
      .i_clk         (i_clk),
      .i_rst         (i_rst),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .i_stall       (i_stall),
      .o_inst        (o_inst),
      .o_inst_valid  (o_inst_valid),
      .o_inst_pc     (o_inst_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_ack    (i_imem_ack),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } entry_t;

   typedef struct {
      int          due;
      logic [31:0] data;
   } mem_rsp_t;

   // Reference model state
   entry_t      m_q[$];
   logic [31:0] m_inflight[$];
   int          m_drop;
   logic [31:0] m_fetch;

   // Behavioural memory
   mem_rsp_t mem_q[$];
   int       lat_min;
   int       lat_max;
   int       last_due;
   logic     mem_served;

   int checks;
   int errors;
   int cyc;

   logic        exp_req;
   logic [31:0] exp_addr;
   logic        exp_valid;
   logic [31:0] exp_inst;
   logic [31:0] exp_pc;

   function automatic logic [97:0] observed();
      return {o_imem_req, o_imem_addr, o_inst_valid, o_inst, o_inst_pc};
   endfunction

   function automatic logic [97:0] expected();
      return {exp_req, exp_addr, exp_valid, exp_inst, exp_pc};
   endfunction

   // Expected outputs for the current cycle from model state and inputs
   function automatic void compute_expect();
      exp_req   = !i_rst && !i_redirect &&
                  ((m_q.size() + m_inflight.size()) < DEPTH) &&
                  ((m_inflight.size() + m_drop) < MAX_OUT);
      exp_addr  = m_fetch;
      exp_valid = (m_q.size() > 0);
      exp_inst  = exp_valid ? m_q[0].inst : 32'd0;
      exp_pc    = exp_valid ? m_q[0].pc   : 32'd0;
   endfunction

   // Apply inputs just after a rising edge, then settle at the falling edge
   task automatic applyStimulus(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic stall, input logic ack, input logic spur);
      i_rst         = rst;
      i_redirect    = redir;
      i_redirect_pc = rpc;
      i_stall       = stall;
      i_imem_ack    = ack;
      mem_served    = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = mem_q[0].data;
         mem_served    = 1'b1;
      end else begin
         i_imem_rvalid = spur && (mem_q.size() == 0);
         i_imem_rdata  = $urandom;
      end
      @(negedge i_clk);
      compute_expect();
   endtask

   // Advance model and memory across the rising edge
   task automatic commit();
      logic   fire;
      logic   keep;
      entry_t e;
      int     d;
      fire = exp_req && i_imem_ack;
      keep = 1'b0;
      e.pc   = 32'd0;
      e.inst = 32'd0;
      if (i_rst) begin
         m_q.delete();
         m_inflight.delete();
         mem_q.delete();
         m_drop  = 0;
         m_fetch = RESET_PC;
      end else begin
         if (mem_served) void'(mem_q.pop_front());
         if (i_imem_rvalid) begin
            if (m_drop > 0) begin
               m_drop--;
            end else if (m_inflight.size() > 0) begin
               e.pc   = m_inflight.pop_front();
               e.inst = i_imem_rdata;
               keep   = 1'b1;
            end
         end
         if (i_redirect) begin
            m_q.delete();
            m_drop = m_drop + m_inflight.size();
            m_inflight.delete();
            m_fetch = i_redirect_pc;
         end else begin
            if (m_q.size() > 0 && !i_stall) void'(m_q.pop_front());
            if (keep) m_q.push_back(e);
            if (fire) begin
               m_inflight.push_back(m_fetch);
               d = cyc + $urandom_range(lat_max, lat_min);
               if (d <= last_due) d = last_due + 1;
               last_due = d;
               mem_q.push_back('{due: d, data: 32'h100 + m_fetch});
               m_fetch = m_fetch + 32'd1;
            end
         end
      end
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL reset cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         commit();
      end
   endtask

   task automatic test_stream();
      lat_min = 1;
      lat_max = 1;
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL stream cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         commit();
      end
   endtask

   task automatic test_stall();
      lat_min = 1;
      lat_max = 1;
      for (int k = 0; k < 22; k++) begin
         applyStimulus(1'b0, 1'b0, 32'd0, (k < 10), 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL stall cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         commit();
      end
   endtask

   task automatic test_redirect();
      int waited;
      lat_min = 3;
      lat_max = 3;
      waited  = 0;
      while (m_inflight.size() != 2 && waited < 20) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL redirect_pre cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         commit();
         waited++;
      end
      if (m_inflight.size() != 2) begin
         checks++;
         errors++;
         $display("[TB] FAIL redirect_wait timeout got=%0d outstanding want=2", m_inflight.size());
      end
      for (int k = 0; k < 24; k++) begin
         applyStimulus(1'b0, (k == 0), 32'h40, 1'b0, 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL redirect cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         checks++;
         if (k > 0 && o_inst_valid && o_inst_pc < 32'h40) begin
            errors++;
            $display("[TB] FAIL redirect_stale got pc=%h want pc>=00000040", o_inst_pc);
         end
         commit();
      end
   endtask

   task automatic test_redirect_collide();
      logic done;
      logic redir;
      lat_min = 1;
      lat_max = 1;
      done    = 1'b0;
      for (int k = 0; k < 20; k++) begin
         redir = !done && (k >= 3) && (mem_q.size() > 0) && (mem_q[0].due <= cyc);
         applyStimulus(1'b0, redir, 32'h200, 1'b0, 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL collide cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         if (redir) done = 1'b1;
         commit();
      end
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL collide_wait timeout got=no rvalid want=rvalid with redirect");
      end
   endtask

   task automatic test_reset_midstream();
      int waited;
      lat_min = 1;
      lat_max = 2;
      waited  = 0;
      while (m_q.size() != DEPTH && waited < 30) begin
         applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL fill cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         commit();
         waited++;
      end
      if (m_q.size() != DEPTH) begin
         checks++;
         errors++;
         $display("[TB] FAIL fill_wait timeout got=%0d entries want=%0d", m_q.size(), DEPTH);
      end
      applyStimulus(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
      commit();
      applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      checks++;
      if ({o_inst_valid, o_inst, o_inst_pc, o_imem_req, o_imem_addr} !== {1'b0, 32'd0, 32'd0, 1'b1, RESET_PC}) begin
         errors++;
         $display("[TB] FAIL reset_mid got v=%0b inst=%h pc=%h req=%0b addr=%h want v=0 inst=0 pc=0 req=1 addr=%h",
                  o_inst_valid, o_inst, o_inst_pc, o_imem_req, o_imem_addr, RESET_PC);
      end
      commit();
   endtask

   task automatic test_wrap();
      lat_min = 1;
      lat_max = 1;
      for (int k = 0; k < 12; k++) begin
         applyStimulus(1'b0, (k == 0), 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0);
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL wrap cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         commit();
      end
   endtask

   task automatic test_random();
      logic [31:0] rpc;
      lat_min = 1;
      lat_max = 4;
      for (int k = 0; k < 600; k++) begin
         rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFD + 32'($urandom_range(0, 2)))
                                           : 32'($urandom_range(0, 255));
         applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) == 0), rpc,
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                       ($urandom_range(0, 4) == 0));
         checks++;
         if (observed() !== expected()) begin
            errors++;
            $display("[TB] FAIL random cyc=%0d got=%h want=%h", cyc, observed(), expected());
         end
         commit();
      end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      cyc      = 0;
      last_due = 0;
      lat_min  = 1;
      lat_max  = 1;
      m_drop   = 0;
      m_fetch  = RESET_PC;
      i_rst         = 1'b1;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'd0;
      i_stall       = 1'b0;
      i_imem_ack    = 1'b0;
      i_imem_rvalid = 1'b0;
      i_imem_rdata  = 32'd0;
      repeat (2) @(posedge i_clk);
      #1;
      test_reset();
      test_stream();
      test_stall();
      test_redirect();
      test_redirect_collide();
      test_reset_midstream();
      test_wrap();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
